// File: rtl/pipeline_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_branch_resolve
// Description : EX-stage branch/JAL/JALR resolution, fetch redirect, squash
//               of wrong-path slots and control-transfer statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_branch_resolve #(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    output logic        pc_select_o,
    output logic [31:0] pc_new_o,
    output logic        flush_o,
    output logic [31:0] link_o,
    output logic        misaligned_o,
    output logic [31:0] branch_count_o,
    output logic [31:0] taken_count_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  squash_cnt_q, squash_cnt_d;
    logic        pc_select_q, pc_select_d;
    logic [31:0] pc_new_q, pc_new_d;
    logic        flush_q, flush_d;
    logic [31:0] link_q, link_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q, taken_count_d;

    logic        cond_true;
    logic [31:0] pc_sum;
    logic [31:0] rs_sum;
    logic [31:0] target;
    logic        taken;
    logic        accept;
    logic        redirect;
    logic        misaligned;

    always_comb begin
        cond_true = 1'b0;
        case (funct3_i)
            3'b000:  cond_true = (rs1_data_i == rs2_data_i);
            3'b001:  cond_true = (rs1_data_i != rs2_data_i);
            3'b100:  cond_true = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            3'b101:  cond_true = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  cond_true = (rs1_data_i <  rs2_data_i);
            3'b111:  cond_true = (rs1_data_i >= rs2_data_i);
            default: cond_true = 1'b0;
        endcase
    end

    // JALR wins over JAL, which wins over a conditional branch
    assign pc_sum     = pc_i + imm_i;
    assign rs_sum     = rs1_data_i + imm_i;
    assign target     = is_jalr_i ? {rs_sum[31:1], 1'b0} : pc_sum;
    assign taken      = is_jalr_i | is_jal_i | (is_branch_i & cond_true);
    assign accept     = valid_i & (state_q == ST_IDLE) & (is_branch_i | is_jal_i | is_jalr_i);
    assign redirect   = accept & taken & (target[1:0] == 2'b00);
    assign misaligned = accept & taken & (target[1:0] != 2'b00);

    always_comb begin
        state_d        = state_q;
        squash_cnt_d   = squash_cnt_q;
        pc_select_d    = 1'b0;
        pc_new_d       = pc_new_q;
        flush_d        = 1'b0;
        link_d         = link_q;
        misaligned_d   = misaligned;
        branch_count_d = branch_count_q + {31'd0, accept};
        taken_count_d  = taken_count_q + {31'd0, redirect};

        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    pc_select_d  = 1'b1;
                    pc_new_d     = target;
                    flush_d      = 1'b1;
                    squash_cnt_d = SQUASH_LOAD;
                    state_d      = (SQUASH_CYCLES == 1) ? ST_IDLE : ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                // Counter hits zero on the last flushed cycle; leave on the next edge
                if (squash_cnt_q == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d      = 1'b1;
                    squash_cnt_d = squash_cnt_q - 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept && (is_jal_i || is_jalr_i)) begin
            link_d = pc_i + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= ST_IDLE;
            squash_cnt_q   <= 3'd0;
            pc_select_q    <= 1'b0;
            pc_new_q       <= 32'd0;
            flush_q        <= 1'b0;
            link_q         <= 32'd0;
            misaligned_q   <= 1'b0;
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            squash_cnt_q   <= squash_cnt_d;
            pc_select_q    <= pc_select_d;
            pc_new_q       <= pc_new_d;
            flush_q        <= flush_d;
            link_q         <= link_d;
            misaligned_q   <= misaligned_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign pc_select_o    = pc_select_q;
    assign pc_new_o       = pc_new_q;
    assign flush_o        = flush_q;
    assign link_o         = link_q;
    assign misaligned_o   = misaligned_q;
    assign branch_count_o = branch_count_q;
    assign taken_count_o  = taken_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_branch_resolve
// Description : Scoreboard bench for pipeline_branch_resolve with a
//               cycle-level reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_branch_resolve;

    localparam int SQ = 2;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        valid_i;
    logic        is_branch_i, is_jal_i, is_jalr_i;
    logic [2:0]  funct3_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic        pc_select_o, flush_o, misaligned_o;
    logic [31:0] pc_new_o, link_o, branch_count_o, taken_count_o;

    pipeline_branch_resolve #(.SQUASH_CYCLES(SQ)) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .valid_i       (valid_i),
        .is_branch_i   (is_branch_i),
        .is_jal_i      (is_jal_i),
        .is_jalr_i     (is_jalr_i),
        .funct3_i      (funct3_i),
        .pc_i          (pc_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .imm_i         (imm_i),
        .pc_select_o   (pc_select_o),
        .pc_new_o      (pc_new_o),
        .flush_o       (flush_o),
        .link_o        (link_o),
        .misaligned_o  (misaligned_o),
        .branch_count_o(branch_count_o),
        .taken_count_o (taken_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        sel;
        logic [31:0] pcn;
        logic        fl;
        logic [31:0] link;
        logic        mis;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: remaining flushed cycles, counters, held values
    int          m_fl;
    logic [31:0] m_pcn, m_link, m_bc, m_tc;

    localparam logic [2:0] K_BR = 3'b001, K_JAL = 3'b010, K_JALR = 3'b100, K_NONE = 3'b000;

    // Monitor: compares every registered output cycle against the oldest expectation
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{sel: pc_select_o, pcn: pc_new_o, fl: flush_o, link: link_o,
                  mis: misaligned_o, bc: branch_count_o, tc: taken_count_o};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got sel=%b pcn=%h fl=%b link=%h mis=%b bc=%h tc=%h, want sel=%b pcn=%h fl=%b link=%h mis=%b bc=%h tc=%h",
                         $time, a.sel, a.pcn, a.fl, a.link, a.mis, a.bc, a.tc,
                         e.sel, e.pcn, e.fl, e.link, e.mis, e.bc, e.tc);
            end
        end
    end

    task automatic model_clear();
        m_fl = 0; m_pcn = '0; m_link = '0; m_bc = '0; m_tc = '0;
    endtask

    task automatic push_zero();
        exp_t e;
        e = '0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [2:0] kind, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm);
        exp_t        e;
        logic [31:0] tgt;
        logic        tk;
        reset_ni    = 1'b1;
        valid_i     = v;
        is_branch_i = kind[0];
        is_jal_i    = kind[1];
        is_jalr_i   = kind[2];
        funct3_i    = f3;
        pc_i        = pc;
        rs1_data_i  = a;
        rs2_data_i  = b;
        imm_i       = imm;

        e.sel = 1'b0;
        e.mis = 1'b0;
        if (m_fl > 0) begin
            m_fl--;
        end else if (v && kind != K_NONE) begin
            if (kind[2]) begin
                tgt = (a + imm) & 32'hFFFF_FFFE;
                tk  = 1'b1;
            end else begin
                tgt = pc + imm;
                if (kind[1]) tk = 1'b1;
                else begin
                    case (f3)
                        3'd0:    tk = (a == b);
                        3'd1:    tk = (a != b);
                        3'd4:    tk = ($signed(a) <  $signed(b));
                        3'd5:    tk = ($signed(a) >= $signed(b));
                        3'd6:    tk = (a <  b);
                        3'd7:    tk = (a >= b);
                        default: tk = 1'b0;
                    endcase
                end
            end
            m_bc = m_bc + 1;
            if (kind[2] || kind[1]) m_link = pc + 4;
            if (tk) begin
                if (tgt % 4 == 0) begin
                    e.sel = 1'b1;
                    m_pcn = tgt;
                    m_tc  = m_tc + 1;
                    m_fl  = SQ;
                end else begin
                    e.mis = 1'b1;
                end
            end
        end
        e.pcn  = m_pcn;
        e.fl   = (m_fl > 0);
        e.link = m_link;
        e.bc   = m_bc;
        e.tc   = m_tc;
        exp_q.push_back(e);
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, K_NONE, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    // Asynchronous reset dropped mid-cycle; outputs must clear before the next sample
    task automatic reset_mid_cycle();
        push_zero();
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        @(negedge clk_i);
        #1;
        model_clear();
        push_zero();
        @(negedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'd5;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'd1;
            4: pick = 32'h8000_0000;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ni = 1'b0; valid_i = 1'b0; is_branch_i = 1'b0; is_jal_i = 1'b0;
        is_jalr_i = 1'b0; funct3_i = '0; pc_i = '0; rs1_data_i = '0;
        rs2_data_i = '0; imm_i = '0;
        model_clear();
        @(negedge clk_i);
        #1;
        for (int i = 0; i < 2; i++) begin
            push_zero();
            @(negedge clk_i);
            #1;
        end

        // BEQ taken, two wrong-path JALs ignored, third JAL redirects
        step(1'b1, K_BR,  3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
        n_tests++;
        if (pc_select_o !== 1'b1) begin
            n_fail++;
            $display("FAIL BEQ: got pc_select_o=%b, want 1", pc_select_o);
        end
        n_tests++;
        if (pc_new_o !== 32'h120) begin
            n_fail++;
            $display("FAIL BEQ: got pc_new_o=%h, want 00000120", pc_new_o);
        end
        step(1'b1, K_JAL, 3'b000, 32'h300, 32'd0, 32'd0, 32'h8);
        step(1'b1, K_JAL, 3'b000, 32'h304, 32'd0, 32'd0, 32'h8);
        step(1'b1, K_JAL, 3'b000, 32'h40,  32'd0, 32'd0, 32'h10);
        n_tests++;
        if (pc_new_o !== 32'h50) begin
            n_fail++;
            $display("FAIL JAL: got pc_new_o=%h, want 00000050", pc_new_o);
        end
        n_tests++;
        if (link_o !== 32'h44) begin
            n_fail++;
            $display("FAIL JAL: got link_o=%h, want 00000044", link_o);
        end
        idle(3);
        // Signed vs unsigned less-than with the same operands
        step(1'b1, K_BR, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
        idle(2);
        step(1'b1, K_BR, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
        n_tests++;
        if (pc_select_o !== 1'b0) begin
            n_fail++;
            $display("FAIL BLTU: got pc_select_o=%b, want 0", pc_select_o);
        end
        // Misaligned JALR target, reserved funct3 branch
        step(1'b1, K_JALR, 3'b000, 32'h80, 32'h203, 32'd0, 32'd0);
        n_tests++;
        if (misaligned_o !== 1'b1) begin
            n_fail++;
            $display("FAIL JALR: got misaligned_o=%b, want 1", misaligned_o);
        end
        step(1'b1, K_BR, 3'b010, 32'h84, 32'd3, 32'd3, 32'h8);
        // Multiple kind bits: JALR takes priority
        step(1'b1, K_JALR | K_BR, 3'b001, 32'h90, 32'h1000, 32'h1000, 32'h4);
        idle(3);
        // Reset in the middle of the squash window
        step(1'b1, K_BR, 3'b000, 32'h100, 32'd7, 32'd7, 32'h40);
        reset_mid_cycle();
        n_tests++;
        if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got flush_o=%b, want 0", flush_o);
        end
        step(1'b1, K_BR, 3'b001, 32'h100, 32'd7, 32'd7, 32'h40);
        idle(2);
        // Taken counter wrap
        force dut.taken_count_q = 32'hFFFF_FFFF;
        #1 release dut.taken_count_q;
        m_tc = 32'hFFFF_FFFF;
        step(1'b1, K_JAL, 3'b000, 32'h0, 32'd0, 32'd0, 32'h100);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  k;
            logic [31:0] imm;
            k   = 3'($urandom_range(0, 7));
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
            step(($urandom_range(0, 9) < 7), k, 3'($urandom), $urandom & 32'hFFFF_FFFC,
                 pick(), pick(), imm);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
